// File: rtl/common_rtlrom_fifoctl.sv
// common_rtlrom_fifoctl: pointer/occupancy controller for a 2^WIDTH-entry circular buffer.
// Define COMMON_RTLROM_FIFOCTL_ALMOST_EN to add the registered afull/aempty outputs.
module common_rtlrom_fifoctl #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             wen,
    input  logic             ren,
    input  logic             clr_err,
    output logic [WIDTH-1:0] waddr,
    output logic [WIDTH-1:0] raddr,
    output logic [WIDTH:0]   count,
    output logic             full,
    output logic             empty,
    output logic             push_ok,
    output logic             pop_ok,
    output logic             ovf,
    output logic             udf
`ifdef COMMON_RTLROM_FIFOCTL_ALMOST_EN
    ,
    output logic             afull,
    output logic             aempty
`endif
);
    localparam logic [WIDTH:0] DEPTH = {1'b1, {WIDTH{1'b0}}};

    logic [WIDTH-1:0] waddr_nxt, raddr_nxt;
    logic [WIDTH:0]   count_nxt;

    assign full    = count == DEPTH;
    assign empty   = count == '0;
    assign push_ok = wen & ~full & ~flush;
    assign pop_ok  = ren & ~empty & ~flush;

    // next pointers wrap naturally; count moves only when exactly one side is accepted
    always_comb begin
        waddr_nxt = flush ? '0 : push_ok ? waddr + 1'b1 : waddr;
        raddr_nxt = flush ? '0 : pop_ok ? raddr + 1'b1 : raddr;
        count_nxt = flush ? '0 :
                    (push_ok & ~pop_ok) ? count + 1'b1 :
                    (pop_ok & ~push_ok) ? count - 1'b1 : count;
    end

    // pointer/count state and sticky errors; a new error beats a same-cycle clear
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            waddr <= '0;
            raddr <= '0;
            count <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else begin
            waddr <= waddr_nxt;
            raddr <= raddr_nxt;
            count <= count_nxt;
            ovf   <= (wen & full & ~flush) | (ovf & ~clr_err);
            udf   <= (ren & empty & ~flush) | (udf & ~clr_err);
        end
    end

`ifdef COMMON_RTLROM_FIFOCTL_ALMOST_EN
    // almost flags from the next count so they line up with full/empty
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            afull  <= 1'b0;
            aempty <= 1'b1;
        end else begin
            afull  <= count_nxt >= DEPTH - 1'b1;
            aempty <= count_nxt <= (WIDTH+1)'(1);
        end
    end
`endif
endmodule

// File: tb/tb_common_rtlrom_fifoctl.sv
// tb_common_rtlrom_fifoctl: scoreboard bench for the circular-buffer pointer controller.
module tb_common_rtlrom_fifoctl;
    localparam int W = 2;
    localparam int D = 1 << W;

    logic clk = 0, resetn = 0, flush = 0, wen = 0, ren = 0, clr_err = 0;
    logic [W-1:0] waddr, raddr;
    logic [W:0]   count;
    logic full, empty, push_ok, pop_ok, ovf, udf;
`ifdef COMMON_RTLROM_FIFOCTL_ALMOST_EN
    logic afull, aempty;
`endif

    always #5 clk = ~clk;

    common_rtlrom_fifoctl #(.WIDTH(W)) dut (
        .clk(clk), .resetn(resetn), .flush(flush), .wen(wen), .ren(ren), .clr_err(clr_err),
        .waddr(waddr), .raddr(raddr), .count(count), .full(full), .empty(empty),
        .push_ok(push_ok), .pop_ok(pop_ok), .ovf(ovf), .udf(udf)
`ifdef COMMON_RTLROM_FIFOCTL_ALMOST_EN
        , .afull(afull), .aempty(aempty)
`endif
    );

    typedef struct {
        int wa, ra, cnt;
        bit pk, rk, ov, ud;
    } exp_t;

    exp_t q[$];
    int total = 0, bad = 0;
    int m_cnt = 0, m_wp = 0, m_rp = 0;
    bit m_ov = 0, m_ud = 0;

    task automatic chk(input string n, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s act=%0d req=%0d at %0t", n, act, req, $time);
        end
    endtask

    // one bus cycle: drive inputs, record what the DUT must show, advance the model
    task automatic cyc(input bit w, input bit r, input bit f = 0, input bit c = 0);
        exp_t e;
        bit pk, rk;
        @(posedge clk);
        #2;
        wen = w; ren = r; flush = f; clr_err = c;
        pk = w && m_cnt != D && !f;
        rk = r && m_cnt != 0 && !f;
        e.wa = m_wp; e.ra = m_rp; e.cnt = m_cnt;
        e.pk = pk; e.rk = rk; e.ov = m_ov; e.ud = m_ud;
        q.push_back(e);
        m_ov = (w && m_cnt == D && !f) || (m_ov && !c);
        m_ud = (r && m_cnt == 0 && !f) || (m_ud && !c);
        if (f) begin
            m_wp = 0; m_rp = 0; m_cnt = 0;
        end else begin
            m_wp = (m_wp + int'(pk)) % D;
            m_rp = (m_rp + int'(rk)) % D;
            m_cnt = m_cnt + int'(pk) - int'(rk);
        end
    endtask

    // monitor: pops one expectation per cycle and compares away from the active edge
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("waddr", int'(waddr), e.wa);
            chk("raddr", int'(raddr), e.ra);
            chk("count", int'(count), e.cnt);
            chk("full", int'(full), int'(e.cnt == D));
            chk("empty", int'(empty), int'(e.cnt == 0));
            chk("push_ok", int'(push_ok), int'(e.pk));
            chk("pop_ok", int'(pop_ok), int'(e.rk));
            chk("ovf", int'(ovf), int'(e.ov));
            chk("udf", int'(udf), int'(e.ud));
`ifdef COMMON_RTLROM_FIFOCTL_ALMOST_EN
            chk("afull", int'(afull), int'(e.cnt >= D - 1));
            chk("aempty", int'(aempty), int'(e.cnt <= 1));
`endif
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #2 resetn = 1;
        cyc(0, 0);
        repeat (4) cyc(1, 0);
        cyc(1, 0);
        repeat (4) cyc(0, 1);
        cyc(0, 1);
        cyc(0, 0, 0, 1);
        repeat (2) cyc(1, 0);
        repeat (6) cyc(1, 1);
        repeat (2) cyc(1, 0);
        cyc(1, 1);
        cyc(0, 0, 0, 1);
        repeat (3) cyc(0, 1);
        cyc(1, 1);
        cyc(0, 0, 0, 1);
        repeat (2) cyc(1, 0);
        cyc(1, 0, 1);
        cyc(0, 0);
        repeat (5) cyc(1, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 1);
        cyc(0, 0);
        @(negedge clk);
        #1;
        wen = 0; ren = 0; flush = 0; clr_err = 0;
        resetn = 0;
        #1;
        chk("rst_waddr", int'(waddr), 0);
        chk("rst_raddr", int'(raddr), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_udf", int'(udf), 0);
        #1 resetn = 1;
        m_cnt = 0; m_wp = 0; m_rp = 0; m_ov = 0; m_ud = 0;
        cyc(0, 0);
        for (int i = 0; i < 10000; i++)
            cyc($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
                $urandom_range(0, 63) == 0, $urandom_range(0, 31) == 0);
        cyc(0, 0);
        cyc(0, 0);
        @(negedge clk);
        #1;
        chk("drain", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
